// File: rtl/iob_pfsm_input_cond.sv
// Input conditioner for the PFSM core: synchronises asynchronous pins, applies
// per-bit polarity inversion, debounces each bit and emits registered rise/fall
// strobes plus an aggregate change strobe. All outputs come straight from flops.
module iob_pfsm_input_cond #(
  parameter int unsigned INPUT_W     = 4,
  parameter int unsigned DEBOUNCE_W  = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DEBOUNCE_W-1:0] cfg_debounce_i,
  input  logic [INPUT_W-1:0]    cfg_invert_i,
  input  logic [INPUT_W-1:0]    pins_i,
  output logic [INPUT_W-1:0]    input_ports_o,
  output logic [INPUT_W-1:0]    rise_o,
  output logic [INPUT_W-1:0]    fall_o,
  output logic                  change_o
);

  logic [SYNC_STAGES-1:0][INPUT_W-1:0] sync_q;
  logic [INPUT_W-1:0]                  raw;
  logic [DEBOUNCE_W-1:0]               thresh;
  logic [INPUT_W-1:0][DEBOUNCE_W-1:0]  cnt_q, cnt_d;
  logic [INPUT_W-1:0]                  stable_q, stable_d;
  logic [INPUT_W-1:0]                  rise_q, rise_d;
  logic [INPUT_W-1:0]                  fall_q, fall_d;
  logic                                change_q, change_d;

  // Synchroniser chain: stage 0 samples the asynchronous pins.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= pins_i;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  // Polarity is applied after the synchroniser so an invert change debounces like a pin edge.
  assign raw = sync_q[SYNC_STAGES-1] ^ cfg_invert_i;

  // Terminal count is N-1; debounce values 0 and 1 both mean a single cycle.
  assign thresh = (cfg_debounce_i < DEBOUNCE_W'(2)) ? '0 : cfg_debounce_i - DEBOUNCE_W'(1);

  // Per-bit debounce next state; >= compare absorbs a mid-count shrink of N.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    for (int i = 0; i < INPUT_W; i++) begin
      if (raw[i] != stable_q[i]) begin
        if (cnt_q[i] >= thresh) begin
          stable_d[i] = raw[i];
        end else begin
          cnt_d[i] = cnt_q[i] + DEBOUNCE_W'(1);
        end
      end
    end
  end

  // Edge strobes are computed from the stable update so they align with the new level.
  always_comb begin
    rise_d   = stable_d & ~stable_q;
    fall_d   = ~stable_d & stable_q;
    change_d = |(rise_d | fall_d);
  end

  // Debounce state and registered strobes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      stable_q <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      change_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      change_q <= change_d;
    end
  end

  assign input_ports_o = stable_q;
  assign rise_o        = rise_q;
  assign fall_o        = fall_q;
  assign change_o      = change_q;

endmodule

// File: tb/tb_iob_pfsm_input_cond.sv
// Directed bench for iob_pfsm_input_cond (INPUT_W=4, DEBOUNCE_W=8, SYNC_STAGES=2).
// Inputs change and outputs are sampled 1 time unit after a rising edge.
module tb_iob_pfsm_input_cond;

  logic       clk;
  logic       rst;
  logic [7:0] cfg_debounce;
  logic [3:0] cfg_invert;
  logic [3:0] pins;
  logic [3:0] input_ports;
  logic [3:0] rise;
  logic [3:0] fall;
  logic       change;

  int checks = 0;
  int errors = 0;

  iob_pfsm_input_cond #(
    .INPUT_W    (4),
    .DEBOUNCE_W (8),
    .SYNC_STAGES(2)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .cfg_debounce_i(cfg_debounce),
    .cfg_invert_i  (cfg_invert),
    .pins_i        (pins),
    .input_ports_o (input_ports),
    .rise_o        (rise),
    .fall_o        (fall),
    .change_o      (change)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] ports, input logic [3:0] r,
                         input logic [3:0] f, input logic c);
    chk({tag, ".ports"}, 8'(input_ports), 8'(ports));
    chk({tag, ".rise"}, 8'(rise), 8'(r));
    chk({tag, ".fall"}, 8'(fall), 8'(f));
    chk({tag, ".change"}, 8'(change), 8'(c));
  endtask

  initial begin
    // 1: reset with pins low, then 20 quiet cycles.
    rst = 1'b1; cfg_debounce = 8'd4; cfg_invert = 4'b0000; pins = 4'b0000;
    step(2);
    chk_all("reset", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step(1);
      chk("quiet.strobes", {rise, fall}, 8'h00);
    end
    chk("quiet.ports", 8'(input_ports), 8'h00);

    // 2: N=4, bit0 rises; level and strobe appear exactly 6 cycles after the edge.
    pins = 4'b0001;
    step(5);
    chk_all("rise0.early", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    step(1);
    chk_all("rise0.edge", 4'b0001, 4'b0001, 4'b0000, 1'b1);
    step(1);
    chk_all("rise0.after", 4'b0001, 4'b0000, 4'b0000, 1'b0);

    // 3a: 3-cycle pulse on bit1 is rejected.
    pins = 4'b0011;
    step(3);
    pins = 4'b0001;
    for (int k = 0; k < 10; k++) begin
      step(1);
      chk("glitch.strobes", {rise, fall}, 8'h00);
    end
    chk("glitch.ports", 8'(input_ports), 8'h01);

    // 3b: 4-cycle pulse passes; fall follows release by 6 cycles.
    pins = 4'b0011;
    step(4);
    pins = 4'b0001;
    step(2);
    chk_all("pulse.rise", 4'b0011, 4'b0010, 4'b0000, 1'b1);
    step(3);
    chk_all("pulse.hold", 4'b0011, 4'b0000, 4'b0000, 1'b0);
    step(1);
    chk_all("pulse.fall", 4'b0001, 4'b0000, 4'b0010, 1'b1);
    step(1);
    chk_all("pulse.after", 4'b0001, 4'b0000, 4'b0000, 1'b0);

    // 4: cfg_debounce=0 behaves as N=1; multiple bits strobe together.
    cfg_debounce = 8'd0;
    pins = 4'b1010;
    step(2);
    chk("n0.early", 8'(input_ports), 8'h01);
    step(1);
    chk_all("n0.edge", 4'b1010, 4'b1010, 4'b0001, 1'b1);

    // 5: invert bit0 with pins low. Inversion sits after the synchroniser, so the
    // transition is seen by the debouncer on the first edge after reset release.
    rst = 1'b1; cfg_debounce = 8'd4; cfg_invert = 4'b0001; pins = 4'b0000;
    step(1);
    chk_all("inv.reset", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    rst = 1'b0;
    step(3);
    chk("inv.early", 8'(input_ports), 8'h00);
    step(1);
    chk_all("inv.edge", 4'b0001, 4'b0001, 4'b0000, 1'b1);

    // 6: N=8, reset when bit2 count is 2; count restarts, rise 10 cycles later.
    rst = 1'b1; cfg_invert = 4'b0000; cfg_debounce = 8'd8;
    step(1);
    rst = 1'b0;
    pins = 4'b0100;
    step(4);
    rst = 1'b1;
    step(1);
    chk_all("midrst", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    rst = 1'b0;
    step(9);
    chk_all("midrst.wait", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    step(1);
    chk_all("midrst.edge", 4'b0100, 4'b0100, 4'b0000, 1'b1);

    // 7: shrinking N mid-count updates on the next edge (count 4 >= new N-1 = 1).
    pins = 4'b1100;
    step(6);
    chk("shrink.early", 8'(input_ports), 8'h04);
    cfg_debounce = 8'd2;
    step(1);
    chk_all("shrink.edge", 4'b1100, 4'b1000, 4'b0000, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
